// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory over a req/ready handshake and buffers one fetched
// instruction until the IF/ID register takes it. Stalls hold the buffer;
// a redirect flushes it and restarts fetching at the redirect target.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_IFIDWrite,
    input  logic        c_redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [5:0]  ctr_out,
    output logic [5:0]  funcode_out,
    output logic [31:0] instru_out,
    output logic [31:0] nextpc_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_nextpc_q, buf_nextpc_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        show_buf;

    // PC increment wraps modulo 2^32; redirect targets are forced word aligned
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirect_pc & ~32'd3;

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_instr_d  = buf_instr_q;
        buf_nextpc_d = buf_nextpc_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (c_redirect) begin
                    pc_d = redirect_target;
                end
            end
            REQ: begin
                if (c_redirect) begin
                    pc_d = redirect_target;
                end else if (imem_ready) begin
                    buf_instr_d  = imem_rdata;
                    buf_nextpc_d = pc_plus4;
                    pc_d         = pc_plus4;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (c_redirect) begin
                    pc_d         = redirect_target;
                    buf_instr_d  = BUBBLE_INSTR;
                    buf_nextpc_d = 32'd0;
                    state_d      = REQ;
                end else if (c_IFIDWrite) begin
                    if (imem_ready) begin
                        buf_instr_d  = imem_rdata;
                        buf_nextpc_d = pc_plus4;
                        pc_d         = pc_plus4;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and buffer registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            buf_instr_q  <= BUBBLE_INSTR;
            buf_nextpc_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_nextpc_q <= buf_nextpc_d;
        end
    end

    // A same-cycle redirect squashes whatever IF/ID would latch right now
    assign show_buf    = (state_q == HOLD) && !c_redirect;
    assign fetch_valid = show_buf;
    assign instru_out  = show_buf ? buf_instr_q : BUBBLE_INSTR;
    assign nextpc_out  = show_buf ? buf_nextpc_q : 32'd0;
    assign ctr_out     = instru_out[31:26];
    assign funcode_out = instru_out[5:0];

    // Request in REQ, or prefetch from HOLD when the buffer is being consumed
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == REQ) ||
                       ((state_q == HOLD) && c_IFIDWrite && !c_redirect);

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the inputs latched by the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction memory through a req/ready handshake.
- Buffers one fetched instruction until the IF/ID register accepts it.
- Handles stall (IF/ID write-enable low) and branch/jump redirect with flush. When it has nothing valid, it presents the NOP bubble encoding.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- BUBBLE_INSTR, 32'hFC000000, instruction word presented when no valid instruction (ctr=6'b111111, funcode=6'b000000).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_IFIDWrite  in  1  IF/ID write enable from hazard unit; 1 at a rising edge = presented outputs consumed.
- c_redirect  in  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  in  32  redirect target, word aligned.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address; equals PC.
- imem_ready  in  1  rdata valid for the current imem_addr this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word.
- fetch_valid  out  1  instru_out holds a real instruction.
- ctr_out  out  6  instru_out[31:26].
- funcode_out  out  6  instru_out[5:0].
- instru_out  out  32  instruction to IF/ID.
- nextpc_out  out  32  address of presented instruction + 4; 0 when bubble.

Behaviour:
- Registers:
  - pc[31:0].
  - buf_instr[31:0].
  - buf_nextpc[31:0].
  - state in {IDLE, REQ, HOLD}.
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, buf_instr=BUBBLE_INSTR, buf_nextpc=0.
  - Outputs: fetch_valid=0, instru_out=32'hFC000000, ctr_out=6'b111111, funcode_out=0, nextpc_out=0, imem_req=0.
- Output mux is combinational:
  - If fetch_valid=1 and c_redirect=0: outputs come from the buffer.
  - Otherwise: bubble values.
  - Result: a redirect flushes the instruction IF/ID would latch in that same cycle.
- fetch_valid=1 only in HOLD.
- imem_addr=pc always.
- imem_req is asserted when:
  - state=REQ; or
  - state=HOLD and c_IFIDWrite=1 and c_redirect=0 (prefetch for back-to-back delivery).
- IDLE: next state REQ (one cycle after reset release).
- REQ:
  - c_redirect=1: pc<=redirect_pc, stay REQ; any imem_ready this cycle is discarded.
  - imem_ready=1: buf_instr<=imem_rdata, buf_nextpc<=pc+4, pc<=pc+4, go HOLD.
  - Otherwise: stay REQ; imem_addr held stable.
- HOLD:
  - c_redirect=1 (priority over everything): pc<=redirect_pc, go REQ, buffer dropped.
  - c_IFIDWrite=0 (stall): hold everything; no request; outputs stable.
  - c_IFIDWrite=1 and imem_ready=1: load buffer from imem_rdata, pc<=pc+4, stay HOLD. Throughput is 1 instruction/cycle.
  - c_IFIDWrite=1 and imem_ready=0: go REQ.
- Latency:
  - Zero-wait memory: first valid instruction 2 cycles after reset release.
  - Redirect to valid target instruction: 1 cycle + memory latency.
- Arithmetic: pc+4 is modulo 2^32 and wraps silently at 32'hFFFFFFFC->0. redirect_pc[1:0] is ignored (forced 0).
- c_redirect in IDLE: pc<=redirect_pc, go REQ.
- Outputs never reflect imem_rdata combinationally; all data comes from the buffer.

Test Plan:
- Reset release, memory always ready, c_IFIDWrite=1, mem[a]=a|32'h20000000 -> imem_addr 0,4,8,... one per cycle; instru_out 32'h20000000, 32'h20000004, ... on consecutive cycles; nextpc_out 4, 8, 12.
- Memory ready after 3 cycles -> imem_req=1 with imem_addr constant 3 cycles; fetch_valid=0 and instru_out=32'hFC000000 throughout; then valid with nextpc_out=4.
- In HOLD at pc 0x8, c_IFIDWrite=0 for 2 cycles -> instru_out/nextpc_out unchanged (nextpc 0x8), imem_req=0, then resume delivering 0x8's successor.
- HOLD with c_IFIDWrite=1, c_redirect=1, redirect_pc=0x40 -> same-cycle outputs bubble (ctr 6'b111111, nextpc 0); next cycle imem_addr=0x40; delivered nextpc_out=0x44.
- REQ with imem_ready=1 and c_redirect=1, redirect_pc=0x100 -> rdata dropped, fetch_valid stays 0, next imem_addr=0x100; pc=32'hFFFFFFFC fetch -> next addr 0.
- rst_n low while REQ waiting -> imem_req=0 and bubble outputs immediately (before next edge); after release, first imem_addr=RESET_PC.
